qam_mapper_param: RTL and testbench
===================================

// Module: qam_mapper_param
// PURPOSE
//   Runtime-selectable Gray-coded constellation mapper (BPSK/QPSK/16QAM, optional 64QAM).
//   Collects a serial bit stream into symbols and emits unit-average-energy I/Q samples.
//   Successor to the fixed QPSK/16QAM mapper; adds valid/ready backpressure and frame-last flush.
//   Sits between the scrambler/interleaver bit stream and the IFFT/pulse-shaping input.
// PARAMETERS
//   OUT_W   16   I/Q width, signed Q2.(OUT_W-2); legal 8..16
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous, active-low reset
//   mode       in   2       0=BPSK 1=QPSK 2=16QAM 3=64QAM; sampled at symbol start
//   din_valid  in   1       input bit valid
//   din_bit    in   1       input bit
//   din_last   in   1       qualifies final bit of frame
//   din_ready  out  1       mapper can accept a bit
//   out_valid  out  1       symbol valid
//   out_ready  in   1       downstream accepts symbol
//   out_re     out  OUT_W   I component, signed Q2.(OUT_W-2)
//   out_im     out  OUT_W   Q component, signed Q2.(OUT_W-2)
//   out_last   out  1       symbol carries end of frame
// BEHAVIOUR
//   - Reset (rst=0 at posedge): bit_cnt=0, buffer=0, out_valid=0, out_re=out_im=0,
//     out_last=0; partial symbol discarded, takes effect mid-symbol too.
//   - Bit accepted when din_valid&&din_ready. bps = 1/2/4/6 per latched mode.
//   - mode latched on acceptance of bit 0 of a symbol; changes mid-symbol ignored.
//   - Bit order: first received bits -> I (MSB first), remaining -> Q.
//     BPSK b0->I, Q=0. QPSK b0->I, b1->Q. 16QAM b0b1->I, b2b3->Q. 64QAM b0b1b2->I, b3b4b5->Q.
//   - Gray per axis: 1b: 0->-A 1->+A. 2b: 00->-3 01->-1 11->+1 10->+3.
//     3b: 000->-7 001->-5 011->-3 010->-1 110->+1 111->+3 101->+5 100->+7.
//   - Level constants for OUT_W=16 (1.0=16384): BPSK 16384; QPSK 11585;
//     16QAM 5181/15543; 64QAM 2528/7584/12641/17697. For OUT_W<16 use
//     16-bit constant >>> (16-OUT_W). Negatives are exact two's complement.
//   - Latency: final bit of symbol accepted in cycle N -> out_valid=1 in cycle N+1.
//   - Output register holds until out_valid&&out_ready; out_re/im/last stable while stalled.
//   - din_ready = !out_valid || out_ready || (bit_cnt != bps-1): non-final bits always
//     accepted; final bit blocked only if output register occupied and not draining.
//   - Simultaneous drain and new-symbol completion in same cycle: new symbol loaded,
//     out_valid stays 1 (full throughput, 1 symbol per bps cycles).
//   - din_last on accepted bit: symbol completed with remaining bits = 0, emitted with
//     out_last=1; bit_cnt -> 0. din_last on final bit of a full symbol: same, no padding.
//   - din_last with partial symbol is subject to same din_ready gating as a final bit.
//   - After drain with no new symbol: out_valid=0, out_re/im hold last value.
// CONFIGURATION
//   QAM_MAPPER_64QAM_EN defined: mode=3 is 64QAM (6 bits, 3-bit Gray, 64QAM levels).
//   Undefined: 64QAM logic/constants omitted; mode=3 behaves exactly as mode=2 (16QAM).
// TESTING
//   QPSK bits 1,0 then 0,1, out_ready=1 -> (+11585,-11585) then (-11585,+11585), 1 cycle after bit 2.
//   16QAM bits 1,0,0,1 -> (+15543,-5181); bits 0,0,1,1 -> (-15543,+5181).
//   BPSK bit 0 with din_last=1 -> (-16384,0), out_last=1; 16QAM 2 bits 1,1 + last -> (+5181,-15543), out_last=1.
//   out_ready=0 for 10 cycles, QPSK stream -> din_ready drops on 2nd bit of 2nd symbol; no loss/dup on release.
//   mode 1->2 toggled mid-symbol -> current symbol QPSK, next 16QAM; rst=0 mid-symbol -> all outputs 0, no emit.
//   With 64QAM_EN: bits 1,0,0,0,1,1 -> (+17697,-7584); without: mode=3 bits 1,0,0,1 -> (+15543,-5181).

Source files
------------

// File: rtl/qam_mapper_param.sv
// qam_mapper_param: serial bits to Gray-coded BPSK/QPSK/16QAM I/Q with valid/ready; 64QAM when QAM_MAPPER_64QAM_EN is defined
module qam_mapper_param #(
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    din_valid,
    input  logic                    din_bit,
    input  logic                    din_last,
    output logic                    din_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic                    out_last
);
`ifdef QAM_MAPPER_64QAM_EN
    localparam int SW = 6;
`else
    localparam int SW = 4;
`endif
    logic [2:0]    bit_cnt, last_idx;
    logic [1:0]    mode_q, mode_in, m, i_g, q_g;
    logic [SW-1:0] buffer, s;
    logic          fin, accept, i_s, q_s;

    function automatic logic signed [OUT_W-1:0] lvl(input logic [1:0] md, input logic sg, input logic [1:0] g);
        logic [15:0] c;
        c = (md == 2'd0) ? 16'd16384 : (md == 2'd1) ? 16'd11585 : (g >= 2'd2) ? 16'd5181 : 16'd15543;
`ifdef QAM_MAPPER_64QAM_EN
        if (md == 2'd3) c = (g == 2'd2) ? 16'd2528 : (g == 2'd3) ? 16'd7584 : (g == 2'd1) ? 16'd12641 : 16'd17697;
`endif
        c = c >> (16 - OUT_W);
        lvl = sg ? c[OUT_W-1:0] : -c[OUT_W-1:0];
    endfunction

`ifdef QAM_MAPPER_64QAM_EN
    assign mode_in = mode;
`else
    assign mode_in = (mode == 2'd3) ? 2'd2 : mode;
`endif
    assign m = (bit_cnt == 3'd0) ? mode_in : mode_q;
    assign last_idx = (m == 2'd0) ? 3'd0 : (m == 2'd1) ? 3'd1 : (m == 2'd2) ? 3'd3 : 3'd5;
    assign fin = din_last || bit_cnt == last_idx;
    assign din_ready = !out_valid || out_ready || !fin;
    assign accept = din_valid && din_ready;
    // bit 0 lands in the MSB; unfilled positions stay zero, which pads a frame-last symbol
    assign s = buffer | ({din_bit, (SW-1)'(0)} >> bit_cnt);

    always_comb begin
        i_s = s[SW-1];
        i_g = {s[SW-2], s[SW-3]};
        q_s = (m == 2'd1) ? s[SW-2] : s[SW-3];
        q_g = {s[SW-4], 1'b0};
`ifdef QAM_MAPPER_64QAM_EN
        if (m == 2'd3) begin
            i_g = s[4:3];
            q_s = s[2];
            q_g = s[1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt   <= '0;
            buffer    <= '0;
            mode_q    <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (bit_cnt == 3'd0) mode_q <= mode_in;
                if (fin) begin
                    bit_cnt   <= '0;
                    buffer    <= '0;
                    out_valid <= 1'b1;
                    out_re    <= lvl(m, i_s, i_g);
                    out_im    <= (m == 2'd0) ? '0 : lvl(m, q_s, q_g);
                    out_last  <= din_last;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    buffer  <= s;
                end
            end
        end
    end
endmodule

// File: tb/tb_qam_mapper_param.sv
// tb_qam_mapper_param: randomized scoreboard bench for qam_mapper_param against a behavioural Gray/level model
module tb_qam_mapper_param;
    localparam int OUT_W = 16;
    logic clk = 0, rst = 0, din_valid = 0, din_bit = 0, din_last = 0, out_ready = 1;
    logic [1:0] mode = 0;
    logic din_ready, out_valid, out_last;
    logic signed [OUT_W-1:0] out_re, out_im;
    int checks = 0, errors = 0, waits = 0, rdy_sel = 0;

    typedef struct { int re; int im; logic last; } exp_t;
    exp_t q[$];
    int mbits[$];
    int mmode = 0;
    bit lat_pend = 0;
    int last_re = 0, last_im = 0;
    logic last_last = 0;

    qam_mapper_param #(.OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .din_valid(din_valid), .din_bit(din_bit),
        .din_last(din_last), .din_ready(din_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = (rdy_sel == 0) ? 1'b1 : (rdy_sel == 1) ? 1'($urandom % 2) : 1'b0;
    end

    function automatic int eff_mode(int md);
`ifdef QAM_MAPPER_64QAM_EN
        return md;
`else
        return (md == 3) ? 2 : md;
`endif
    endfunction

    function automatic int bps(int md);
        return (md == 0) ? 1 : (md == 1) ? 2 : (md == 2) ? 4 : 6;
    endfunction

    // n-bit Gray code -> odd level -> amplitude from the per-mode magnitude table
    function automatic int axis(int md, int code, int n);
        int b, lv, a, mg;
        b = code ^ (code >> 1) ^ (code >> 2);
        lv = 2 * b - ((1 << n) - 1);
        a = (lv < 0) ? -lv : lv;
        case (md)
            0: mg = 16384;
            1: mg = 11585;
            2: mg = (a == 1) ? 5181 : 15543;
            default: mg = (a == 1) ? 2528 : (a == 3) ? 7584 : (a == 5) ? 12641 : 17697;
        endcase
        mg = mg >> (16 - OUT_W);
        return (lv < 0) ? -mg : mg;
    endfunction

    task automatic emit(input logic l);
        exp_t e;
        int n, ci, cq;
        n = (mmode == 0) ? 1 : (mmode == 1) ? 1 : (mmode == 2) ? 2 : 3;
        while (mbits.size() < bps(mmode)) mbits.push_back(0);
        ci = 0;
        cq = 0;
        for (int i = 0; i < n; i++) ci = ci * 2 + mbits[i];
        for (int i = 0; i < n; i++) cq = cq * 2 + ((mmode == 0) ? 0 : mbits[n + i]);
        e.re = axis(mmode, ci, n);
        e.im = (mmode == 0) ? 0 : axis(mmode, cq, n);
        e.last = l;
        q.push_back(e);
        mbits.delete();
    endtask

    // reference model: observes accepted bits mid-cycle
    always @(negedge clk) begin
        if (lat_pend) begin
            checks++;
            if (!out_valid) begin
                errors++;
                $display("FAIL latency: out_valid=%0b required 1 one cycle after final bit", out_valid);
            end
            lat_pend = 0;
        end
        if (!rst) begin
            mbits.delete();
            q.delete();
        end else if (din_valid && din_ready) begin
            if (mbits.size() == 0) mmode = eff_mode(int'(mode));
            mbits.push_back(int'(din_bit));
            if (din_last || mbits.size() == bps(mmode)) begin
                emit(din_last);
                lat_pend = 1;
            end
        end
    end

    // monitor: pops and compares on every output handshake
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_symbol: got re=%0d im=%0d last=%0b, none expected", out_re, out_im, out_last);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (int'(out_re) != e.re || int'(out_im) != e.im || out_last != e.last) begin
                    errors++;
                    $display("FAIL symbol: got re=%0d im=%0d last=%0b required re=%0d im=%0d last=%0b",
                             out_re, out_im, out_last, e.re, e.im, e.last);
                end
            end
            last_re = int'(out_re);
            last_im = int'(out_im);
            last_last = out_last;
        end
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic put(input logic [1:0] md, input logic b, input logic l);
        din_valid = 1;
        mode = md;
        din_bit = b;
        din_last = l;
        waits = 0;
        forever begin
            @(negedge clk);
            if (din_ready) break;
            if (++waits > 200) begin
                errors++;
                $display("FAIL din_ready_timeout: din_ready=0 for %0d cycles required 1", waits);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        din_valid = 0;
        din_last = 0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) break;
        end
        chk("drain_timeout", int'(k < 200), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_last(input string name, input int re, input int im, input logic l);
        drain();
        chk({name, "_re"}, last_re, re);
        chk({name, "_im"}, last_im, im);
        chk({name, "_last"}, int'(last_last), int'(l));
    endtask

    task automatic sym(input logic [1:0] md, input int n, input logic [5:0] b, input logic l);
        for (int i = 0; i < n; i++) put(md, b[5-i], l && i == n - 1);
    endtask

    initial begin
        int w3, nb;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_re", int'(out_re), 0);
        chk("reset_im", int'(out_im), 0);
        chk("reset_last", int'(out_last), 0);
        @(posedge clk);
        #1;
        rst = 1;
        sym(1, 2, 6'b100000, 0);
        expect_last("qpsk_a", 11585, -11585, 0);
        sym(1, 2, 6'b010000, 0);
        expect_last("qpsk_b", -11585, 11585, 0);
        sym(2, 4, 6'b100100, 0);
        expect_last("qam16_a", 15543, -5181, 0);
        sym(2, 4, 6'b001100, 0);
        expect_last("qam16_b", -15543, 5181, 0);
        sym(0, 1, 6'b000000, 1);
        expect_last("bpsk_last", -16384, 0, 1);
        sym(2, 2, 6'b110000, 1);
        expect_last("qam16_flush", 5181, -15543, 1);
        put(1, 1, 0);
        put(2, 1, 0);
        expect_last("mode_hold", 11585, 11585, 0);
        sym(2, 4, 6'b011000, 0);
        expect_last("mode_next", -5181, 15543, 0);
`ifdef QAM_MAPPER_64QAM_EN
        sym(3, 6, 6'b100011, 0);
        expect_last("qam64", 17697, -7584, 0);
`else
        sym(3, 4, 6'b100100, 0);
        expect_last("mode3_as_16", 15543, -5181, 0);
`endif
        rdy_sel = 2;
        @(posedge clk);
        #3;
        fork
            begin
                repeat (10) @(posedge clk);
                rdy_sel = 0;
            end
        join_none
        put(1, 1, 0);
        put(1, 0, 0);
        put(1, 0, 0);
        w3 = waits;
        put(1, 1, 0);
        chk("stall_bit3_ready", int'(w3 == 0), 1);
        chk("stall_bit4_blocked", int'(waits > 0), 1);
        expect_last("stall_release", -11585, 11585, 0);
        put(2, 1, 0);
        put(2, 1, 0);
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_re", int'(out_re), 0);
        chk("midrst_im", int'(out_im), 0);
        chk("midrst_last", int'(out_last), 0);
        @(posedge clk);
        #1;
        rst = 1;
        sym(2, 4, 6'b000000, 0);
        expect_last("after_rst", -15543, -15543, 0);
        rdy_sel = 1;
        nb = 0;
        for (int i = 0; i < 600; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 2) begin
                repeat (gap - 2) @(posedge clk);
                #1;
            end
            put(2'($urandom % 4), 1'($urandom % 2), 1'($urandom % 10 == 0));
        end
        put(0, 1, 1);
        rdy_sel = 0;
        drain();
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
